// File: rtl/chunked_seq_adder.sv
// Multi-cycle two's-complement adder/subtractor that resolves CHUNK bits per clock,
// carrying between chunks in a register; start/done handshake with signed overflow.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             c_q;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    // Operands of equal sign producing a result of the other sign cannot be represented.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        signed_ovf = (sa == sb) && (sr != sa);
    endfunction

    always_comb begin
        a_ch   = '0;
        b_ch   = '0;
        acc_nx = acc;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        ch_sum = chunk_add(a_ch, b_ch, c_q);
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                acc_nx[i*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
            end
        end
    end

    assign busy = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            acc   <= '0;
            idx   <= '0;
            c_q   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        c_q   <= sub | cin;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_nx;
                    c_q <= ch_sum[CHUNK];
                    idx <= idx + 1'b1;
                    // Outputs are only touched here, so partial sums never leak out.
                    if (idx == LAST) begin
                        sum   <= acc_nx;
                        cout  <= ch_sum[CHUNK];
                        ovf   <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], acc_nx[WIDTH-1]);
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder: directed and random operations on a 16/4 instance
// plus a random sweep over further WIDTH/CHUNK combinations against an arithmetic model.
module tb_chunked_seq_adder;
    localparam int W   = 16;
    localparam int C   = 4;
    localparam int NCH = W / C;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        longint      due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sw_rst_n;
    logic         start;
    logic         cin;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int     total = 0;
    int     bad = 0;
    int     sw_finished = 0;
    longint cyc = 0;
    longint last_done = -1;
    longint prev_done = -1;
    exp_t   q[$];

    always @(posedge clk) cyc <= cyc + 1;

    chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic mark_sweep_done();
        sw_finished++;
    endtask

    // Reference: integer arithmetic on w-bit values; overflow from the exact signed result.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                           input logic ci, input logic sb);
        logic [63:0] mask;
        logic [63:0] yb;
        logic [64:0] full;
        logic        c0;
        longint      sx;
        longint      sy;
        longint      ideal;
        longint      lim;
        mask  = (64'd1 << w) - 64'd1;
        x     = x & mask;
        y     = y & mask;
        yb    = sb ? (~y & mask) : y;
        c0    = sb ? 1'b1 : ci;
        full  = {1'b0, x} + {1'b0, yb} + {64'd0, c0};
        sx    = longint'(x << (64 - w)) >>> (64 - w);
        sy    = longint'(y << (64 - w)) >>> (64 - w);
        ideal = sb ? (sx - sy) : (sx + sy + (ci ? 64'sd1 : 64'sd0));
        lim   = longint'(1) << (w - 1);
        return {full[w], (ideal >= lim) || (ideal < -lim), full[63:0] & mask};
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            3:       return mask >> 1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            check("busy_with_done", {63'd0, busy}, 64'd0);
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("sum", {48'd0, sum}, e.sum);
                check("cout", {63'd0, cout}, {63'd0, e.cout});
                check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                check("latency", cyc, e.due);
            end
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic is, input logic use_exp, input logic [W-1:0] es,
                         input logic ec, input logic eo);
        exp_t        e;
        logic [65:0] r;
        wait_idle();
        a = ia;
        b = ib;
        cin = ic;
        sub = is;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (use_exp) begin
            e.sum  = {48'd0, es};
            e.cout = ec;
            e.ovf  = eo;
        end else begin
            r      = ref_op(W, {48'd0, ia}, {48'd0, ib}, ic, is);
            e.sum  = r[63:0];
            e.cout = r[65];
            e.ovf  = r[64];
        end
        e.due = cyc + NCH;
        q.push_back(e);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("drain", q.size(), 64'd0);
    endtask

    localparam int NSW = 6;
    localparam int SWW[NSW] = '{8, 8, 16, 16, 32, 32};
    localparam int SWC[NSW] = '{1, 4, 1, 16, 4, 16};

    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
        localparam int GW = SWW[gi];
        localparam int GC = SWC[gi];
        localparam int GN = GW / GC;

        logic          s_start;
        logic          s_cin;
        logic          s_sub;
        logic          s_busy;
        logic          s_done;
        logic          s_cout;
        logic          s_ovf;
        logic [GW-1:0] s_a;
        logic [GW-1:0] s_b;
        logic [GW-1:0] s_sum;
        exp_t          sq[$];

        chunked_seq_adder #(.WIDTH(GW), .CHUNK(GC)) u_sw (
            .clk(clk), .rst_n(sw_rst_n), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
            .sub(s_sub), .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
        );

        always @(negedge clk) begin
            if (s_done) begin
                exp_t        e;
                logic [63:0] got;
                got = '0;
                got[GW-1:0] = s_sum;
                if (sq.size() == 0) begin
                    check("sw_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sq.pop_front();
                    check("sw_sum", got, e.sum);
                    check("sw_cout", {63'd0, s_cout}, {63'd0, e.cout});
                    check("sw_ovf", {63'd0, s_ovf}, {63'd0, e.ovf});
                    check("sw_latency", cyc, e.due);
                end
            end
        end

        initial begin
            exp_t        e;
            logic [65:0] r;
            logic [63:0] ta;
            logic [63:0] tb;
            int          g;
            s_start = 1'b0;
            s_a = '0;
            s_b = '0;
            s_cin = 1'b0;
            s_sub = 1'b0;
            wait (sw_rst_n === 1'b1);
            @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                g = 0;
                while (s_busy && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                ta = pick(GW);
                tb = pick(GW);
                s_a = ta[GW-1:0];
                s_b = tb[GW-1:0];
                s_cin = 1'($urandom_range(0, 1));
                s_sub = 1'($urandom_range(0, 1));
                s_start = 1'b1;
                @(posedge clk);
                #1;
                r = ref_op(GW, ta, tb, s_cin, s_sub);
                e.sum = r[63:0];
                e.cout = r[65];
                e.ovf = r[64];
                e.due = cyc + GN;
                sq.push_back(e);
                s_start = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            g = 0;
            while (sq.size() != 0 && g < 200) begin
                @(negedge clk);
                g++;
            end
            @(negedge clk);
            check("sw_drain", sq.size(), 64'd0);
            mark_sweep_done();
        end
    end

    initial begin
        logic [63:0] ta;
        logic [63:0] tb;
        int          g;
        rst_n = 1'b0;
        sw_rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum", {48'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sw_rst_n = 1'b1;

        // Test-plan vectors, issued back to back (each one lands in the previous done cycle).
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();
        check("back_to_back_gap", last_done - prev_done, 64'd5);

        // Extra start mid-run plus operand churn must not disturb the first operation.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        sub = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (busy && g < 50) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            g++;
        end
        drain();

        // Reset during the third cycle of a run discards it.
        issue(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_sum", {48'd0, sum}, 64'd0);
        check("midrst_cout", {63'd0, cout}, 64'd0);
        check("midrst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0);
        drain();

        for (int n = 0; n < 1000; n++) begin
            ta = pick(W);
            tb = pick(W);
            issue(ta[W-1:0], tb[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'b0, 16'h0000, 1'b0, 1'b0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        g = 0;
        while (sw_finished < NSW && g < 40000) begin
            @(negedge clk);
            g++;
        end
        check("sweep_finished", 64'(sw_finished), 64'(NSW));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
